// File: rtl/rom_bridge_pkg.sv
// Shared types and defaults for the drive-ROM bus bridge and its checksum scanner.
package rom_bridge_pkg;

    localparam int ROM_AW_DEF = 15;
    localparam int CPU_AW_DEF = 16;
    localparam int DW_DEF     = 8;
    localparam int CSUM_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SCAN  = 2'd3
    } state_e;

endpackage

// File: rtl/rom_bus_bridge_if.sv
// CPU-side request/response bus of the ROM bridge; master = CPU, slave = bridge.
interface rom_bus_bridge_if
    import rom_bridge_pkg::*;
#(
    parameter int CPU_AW = CPU_AW_DEF,
    parameter int DW     = DW_DEF
);
    logic              req;
    logic [CPU_AW-1:0] addr;
    logic              rw;
    logic              rdy;
    logic              sel;
    logic [DW-1:0]     data;
    logic              data_valid;
    logic              wr_err;
    logic              overrun;

    modport master (output req, addr, rw,
                    input  rdy, sel, data, data_valid, wr_err, overrun);
    modport slave  (input  req, addr, rw,
                    output rdy, sel, data, data_valid, wr_err, overrun);
endinterface

// File: rtl/rom_csum_scanner.sv
// Post-reset ROM sweep: issues one address per cycle, captures one cycle later,
// and accumulates a 16-bit byte sum. Used only when ROM_CHECKSUM_EN is defined.
module rom_csum_scanner
    import rom_bridge_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     rom_data_i,
    output logic [ROM_AW-1:0] scan_addr_o,
    output logic              scan_oe_o,
    output logic              done_o,
    output logic [CSUM_W-1:0] sum_o
);
    logic [ROM_AW:0]     cnt_q;
    logic [ROM_AW-1:0]   addr_q;
    logic                oe_q, cap_q, last_oe_q, last_cap_q, done_q;
    logic [CSUM_W-1:0]   sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            oe_q       <= 1'b0;
            cap_q      <= 1'b0;
            last_oe_q  <= 1'b0;
            last_cap_q <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
        end else begin
            // cnt_q MSB set means every address has been issued
            if (!cnt_q[ROM_AW]) begin
                oe_q      <= 1'b1;
                addr_q    <= cnt_q[ROM_AW-1:0];
                cnt_q     <= cnt_q + (ROM_AW+1)'(1);
                last_oe_q <= &cnt_q[ROM_AW-1:0];
            end else begin
                oe_q      <= 1'b0;
                last_oe_q <= 1'b0;
            end
            cap_q      <= oe_q;
            last_cap_q <= last_oe_q;
            if (cap_q)
                sum_q <= sum_q + CSUM_W'(rom_data_i);
            if (last_cap_q)
                done_q <= 1'b1;
        end
    end

    assign scan_addr_o = addr_q;
    assign scan_oe_o   = oe_q;
    assign done_o      = done_q;
    assign sum_o       = sum_q;
endmodule

// File: rtl/rom_bus_bridge.sv
// CPU-to-drive-ROM read bridge absorbing the ROM's one-cycle registered latency.
// Optional post-reset checksum sweep is built when ROM_CHECKSUM_EN is defined.
//
// state    | meaning
// IDLE     | ready; decode and accept a CPU request
// ISSUE    | rom_oe high, ROM latches addressed byte this cycle
// WAIT     | ROM byte on rom_data, captured into cpu_data at the edge
// SCAN     | checksum sweep owns the ROM port (ROM_CHECKSUM_EN only)
module rom_bus_bridge
    import rom_bridge_pkg::*;
#(
    parameter int ROM_AW      = ROM_AW_DEF,
    parameter int CPU_AW      = CPU_AW_DEF,
    parameter int DW          = DW_DEF,
    parameter bit ROM_SEL_MSB = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    rom_bus_bridge_if.slave       cpu,
    output logic [ROM_AW-1:0]     rom_addr_o,
    output logic                  rom_oe_o,
    input  logic [DW-1:0]         rom_data_i,
    output logic                  csum_done_o,
    output logic [CSUM_W-1:0]     csum_value_o
);
`ifdef ROM_CHECKSUM_EN
    localparam state_e RST_STATE = ST_SCAN;
`else
    localparam state_e RST_STATE = ST_IDLE;
`endif

    state_e            state_q, state_d;
    logic              rdy_q, rdy_d, sel_q, sel_d;
    logic [DW-1:0]     data_q, data_d;
    logic              valid_q, valid_d, wr_err_q, wr_err_d, ovr_q, ovr_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              oe_q, oe_d;
    logic              scan_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RST_STATE;
            rdy_q    <= 1'b1;
            sel_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
            ovr_q    <= 1'b0;
            addr_q   <= '0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_err_q <= wr_err_d;
            ovr_q    <= ovr_d;
            addr_q   <= addr_d;
            oe_q     <= oe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        sel_d    = sel_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        wr_err_d = 1'b0;
        ovr_d    = 1'b0;
        addr_d   = addr_q;
        oe_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy_d = 1'b1;
                if (cpu.req) begin
                    if (cpu.addr[CPU_AW-1] == ROM_SEL_MSB) begin
                        sel_d = 1'b1;
                        if (cpu.rw) begin
                            addr_d  = cpu.addr[ROM_AW-1:0];
                            oe_d    = 1'b1;
                            rdy_d   = 1'b0;
                            state_d = ST_ISSUE;
                        end else begin
                            wr_err_d = 1'b1;
                        end
                    end else begin
                        sel_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                ovr_d   = cpu.req;
                rdy_d   = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                ovr_d   = cpu.req;
                data_d  = rom_data_i;
                valid_d = 1'b1;
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef ROM_CHECKSUM_EN
            ST_SCAN: begin
                ovr_d = cpu.req;
                rdy_d = 1'b0;
                if (scan_done) begin
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu.rdy        = rdy_q;
    assign cpu.sel        = sel_q;
    assign cpu.data       = data_q;
    assign cpu.data_valid = valid_q;
    assign cpu.wr_err     = wr_err_q;
    assign cpu.overrun    = ovr_q;

`ifdef ROM_CHECKSUM_EN
    logic [ROM_AW-1:0] scan_addr;
    logic              scan_oe;

    rom_csum_scanner #(.ROM_AW(ROM_AW), .DW(DW)) u_scanner (
        .clk         (clk),
        .rst         (rst),
        .rom_data_i  (rom_data_i),
        .scan_addr_o (scan_addr),
        .scan_oe_o   (scan_oe),
        .done_o      (scan_done),
        .sum_o       (csum_value_o)
    );

    // The sweep owns the ROM port for as long as the FSM sits in SCAN
    assign rom_addr_o  = (state_q == ST_SCAN) ? scan_addr : addr_q;
    assign rom_oe_o    = (state_q == ST_SCAN) ? scan_oe   : oe_q;
    assign csum_done_o = scan_done;
`else
    assign scan_done    = 1'b0;
    assign rom_addr_o   = addr_q;
    assign rom_oe_o     = oe_q;
    assign csum_done_o  = 1'b1;
    assign csum_value_o = '0;
`endif
endmodule

// File: tb/tb_rom_bus_bridge.sv
// Randomized bench for rom_bus_bridge with a behavioural ROM and transaction-level model.
// Also covers the ROM_CHECKSUM_EN sweep when that macro is defined.
module tb_rom_bus_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] rom_addr;
    logic        rom_oe;
    logic [7:0]  rom_data;
    logic        csum_done;
    logic [15:0] csum_value;

    rom_bus_bridge_if #(.CPU_AW(16), .DW(8)) bus ();

    rom_bus_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (bus),
        .rom_addr_o   (rom_addr),
        .rom_oe_o     (rom_oe),
        .rom_data_i   (rom_data),
        .csum_done_o  (csum_done),
        .csum_value_o (csum_value)
    );

    always #5 clk = ~clk;

    // Registered ROM: data only meaningful the cycle after oe; junk otherwise
    logic [7:0] mem [32768];
    logic [7:0] rom_q;
    logic       rom_vld = 1'b0;
    always @(posedge clk) begin
        rom_q   <= mem[rom_addr];
        rom_vld <= rom_oe;
    end
    assign rom_data = rom_vld ? rom_q : 8'hEE;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_sel  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   bus.rdy, 1);
        chk({tag, "_sel"},   bus.sel, 0);
        chk({tag, "_data"},  bus.data, 0);
        chk({tag, "_valid"}, bus.data_valid, 0);
        chk({tag, "_wrerr"}, bus.wr_err, 0);
        chk({tag, "_ovr"},   bus.overrun, 0);
        chk({tag, "_raddr"}, rom_addr, 0);
        chk({tag, "_oe"},    rom_oe, 0);
    endtask

    // One CPU request; expectations come from the decode/latency rules.
    // extra: 0 none, 1 dropped request in cycle 1, 2 dropped request in cycle 2
    task automatic txn(input logic [15:0] addr, input logic rw, input int extra);
        logic hit;
        hit = addr[15];
        bus.req = 1'b1; bus.addr = addr; bus.rw = rw;
        @(negedge clk);
        if (hit && rw) begin
            bus.req = (extra == 1); bus.addr = 16'($urandom); bus.rw = 1'($urandom);
            chk("c1_oe",    rom_oe, 1);
            chk("c1_raddr", rom_addr, addr[14:0]);
            chk("c1_rdy",   bus.rdy, 0);
            chk("c1_sel",   bus.sel, 1);
            chk("c1_valid", bus.data_valid, 0);
            chk("c1_wrerr", bus.wr_err, 0);
            @(negedge clk);
            bus.req = (extra == 2);
            chk("c2_oe",    rom_oe, 0);
            chk("c2_rdy",   bus.rdy, 0);
            chk("c2_valid", bus.data_valid, 0);
            chk("c2_ovr",   bus.overrun, (extra == 1));
            chk("c2_data",  bus.data, exp_data);
            @(negedge clk);
            bus.req  = 1'b0;
            exp_data = mem[addr[14:0]];
            exp_sel  = 1'b1;
            chk("c3_valid", bus.data_valid, 1);
            chk("c3_data",  bus.data, exp_data);
            chk("c3_rdy",   bus.rdy, 1);
            chk("c3_ovr",   bus.overrun, (extra == 2));
            chk("c3_oe",    rom_oe, 0);
        end else begin
            bus.req = 1'b0;
            exp_sel = hit;
            chk("nr_wrerr", bus.wr_err, (hit && !rw));
            chk("nr_sel",   bus.sel, exp_sel);
            chk("nr_oe",    rom_oe, 0);
            chk("nr_rdy",   bus.rdy, 1);
            chk("nr_valid", bus.data_valid, 0);
            chk("nr_data",  bus.data, exp_data);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_rdy",   bus.rdy, 1);
            chk("idle_valid", bus.data_valid, 0);
            chk("idle_wrerr", bus.wr_err, 0);
            chk("idle_ovr",   bus.overrun, 0);
            chk("idle_oe",    rom_oe, 0);
            chk("idle_data",  bus.data, exp_data);
            chk("idle_sel",   bus.sel, exp_sel);
        end
    endtask

    task automatic wait_scan(input logic do_ovr);
`ifdef ROM_CHECKSUM_EN
        logic [15:0] model_sum;
        int          n;
        model_sum = 16'h0;
        for (int a = 0; a < 32768; a++) model_sum = model_sum + 16'(mem[a]);
        n = 0;
        while (!csum_done && n < 40000) begin
            @(negedge clk);
            if (do_ovr && n == 50) begin
                bus.req = 1'b1; bus.addr = 16'h8000; bus.rw = 1'b1;
            end else if (do_ovr && n == 51) begin
                bus.req = 1'b0;
                chk("scan_ovr", bus.overrun, 1);
                chk("scan_rdy", bus.rdy, 0);
            end
            n++;
        end
        chk("scan_done", csum_done, 1);
        chk("scan_sum",  csum_value, model_sum);
        @(negedge clk);
        @(negedge clk);
        chk("scan_rdy_after", bus.rdy, 1);
        chk("scan_sum_hold",  csum_value, model_sum);
`else
        chk("tied_done", csum_done, 1);
        chk("tied_sum",  csum_value, 0);
`endif
    endtask

    initial begin
        int   kind, extra;
        logic [15:0] a;
        bus.req = 1'b0; bus.addr = 16'h0; bus.rw = 1'b1;
`ifdef ROM_CHECKSUM_EN
        for (int i = 0; i < 32768; i++) mem[i] = 8'(i);
`else
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[15'h0123] = 8'hA5;
`endif
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
`ifndef ROM_CHECKSUM_EN
        chk("rst0_done", csum_done, 1);
`else
        chk("rst0_done", csum_done, 0);
`endif
        rst = 1'b0;
        wait_scan(1'b1);

        txn(16'h8123, 1'b1, 0);
        idle_cycles(1);
        txn(16'h4000, 1'b1, 0);
        idle_cycles(1);
        txn(16'hC000, 1'b0, 0);
        idle_cycles(1);
        txn(16'hFFFC, 1'b1, 1);
        idle_cycles(2);
        txn(16'h8000, 1'b1, 2);
        txn(16'hFFFF, 1'b1, 0);

        for (int t = 0; t < 300; t++) begin
            kind  = $urandom_range(0, 3);
            a     = 16'($urandom);
            extra = $urandom_range(0, 2);
            case (kind)
                0, 1: txn({1'b1, a[14:0]}, 1'b1, extra);
                2:    txn({1'b1, a[14:0]}, 1'b0, 0);
                default: txn({1'b0, a[14:0]}, 1'($urandom), 0);
            endcase
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        // Reset during WAIT discards the in-flight read
        bus.req = 1'b1; bus.addr = 16'h8123; bus.rw = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rstmid");
        @(negedge clk);
        chk_reset_vals("rstmid_next");
        rst = 1'b0;
        exp_data = 8'h00; exp_sel = 1'b0;
        wait_scan(1'b0);
        idle_cycles(2);
        txn(16'h8123, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
